cam_stream_tx: RTL and testbench
================================

Name: cam_stream_tx

Overview:
- Camera-side transmitter for the DVS capture path: generates OV-style frame timing (vsync, href) plus a byte stream (pix_data) with a one-cycle byte strobe.
- Drives the capture block's pclk-domain inputs directly: pix_data, vsync, href, and pix_valid into write_enable_in.
- Used as a synthesizable sensor stand-in for bring-up without a camera, and as a bench stimulus source.
- Content comes from a selectable test-pattern generator.

Parameters:
- H_BYTES, 320: bytes per active line (160 pixels x 2 bytes).
- V_LINES, 150: active lines per frame.
- BYTE_DIV, 4: pclk cycles per byte slot; must be >= 2.
- STROBE_OFS, 1: cycle within a slot at which pix_valid pulses; 0 < STROBE_OFS < BYTE_DIV.
- VSYNC_LEN, 1: vsync high cycles.
- V_BACK, 1: idle cycles between vsync fall and the first line blank.
- H_BLANK, 1: href-low cycles before each line.
- BASE_VAL, 10: constant for pattern 0.

Ports:
- pclk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: start/continue frames.
- pattern_sel, in, 2: pattern select.
- vsync, out, 1: frame sync.
- href, out, 1: line active.
- pix_data, out, 8: byte.
- pix_valid, out, 1: one-cycle byte strobe.
- frame_done, out, 1: one-cycle pulse at end of frame.
- busy, out, 1: high when not IDLE.

Behaviour:
- One clock, pclk; reset is asynchronous and active-high. Asserting reset forces state IDLE and clears all counters.
- Reset values of all outputs are 0, including pix_data = 8'd0.
- All outputs are registered.
- States:
  - IDLE: all outputs 0. If enable=1, go to VSYNC on the next edge.
  - VSYNC: vsync=1 for VSYNC_LEN cycles, then VBACK.
  - VBACK: all low for V_BACK cycles, then HBLANK with row=0.
  - HBLANK: href=0 for H_BLANK cycles, then ACTIVE with byte_idx=0 and slot_cnt=0.
  - ACTIVE: href=1 for exactly H_BYTES*BYTE_DIV cycles.
    - slot_cnt counts 0..BYTE_DIV-1.
    - pix_data is updated at slot_cnt=0 and held for the whole slot.
    - pix_valid=1 only at slot_cnt=STROBE_OFS.
    - byte_idx increments at the end of each slot.
    - After the last slot, row increments.
    - If row was V_LINES-1: pulse frame_done for one cycle (the cycle href falls), increment frame_cnt (8-bit, wraps 255->0), then go to VSYNC if enable=1, else IDLE.
    - Otherwise go to HBLANK.
- Frame period is VSYNC_LEN + V_BACK + V_LINES*(H_BLANK + H_BYTES*BYTE_DIV) cycles. With defaults this is 192152.
- enable is sampled only in IDLE and at end of frame. Deasserting it mid-frame completes the current frame.
- pattern_sel is latched at VSYNC entry and held for the whole frame.
- Patterns. All arithmetic is modulo 256, truncated to 8 bits.
  - 0: BASE_VAL.
  - 1: (byte_idx[1:0]+1)*10, giving 10, 20, 30, 40 repeating.
  - 2: byte_idx[7:0] + frame_cnt.
  - 3: row[7:0] ^ byte_idx[7:0].
- Outside ACTIVE, pix_data holds its last value; it is 0 after reset.
- pix_valid is never high when href=0. vsync and href are never high together.
- Counter widths: byte_idx is $clog2(H_BYTES) bits; row is $clog2(V_LINES) bits; slot_cnt is $clog2(BYTE_DIV) bits.
- Reset asserted mid-line: href, pix_valid and vsync drop asynchronously. No frame_done is pulsed.

Decomposition:
- Shared package cam_stream_pkg:
  - state enum (IDLE, VSYNC, VBACK, HBLANK, ACTIVE);
  - pattern codes PAT_CONST, PAT_RAMP, PAT_INCR, PAT_XOR.
- Sub-module cam_pattern_gen: purely combinational function of (pattern, byte_idx, row, frame_cnt, BASE_VAL) -> byte. The top registers its output.

Test Plan (H_BYTES=8, V_LINES=3, BYTE_DIV=4, STROBE_OFS=1, VSYNC_LEN=1, V_BACK=1, H_BLANK=1; frame = 101 cycles):
- Frame timing: reset 2 cycles, enable=1 held, pattern 1 -> vsync high for 1 cycle; per line href high for 32 cycles after 1 low cycle; 3 lines; 24 pix_valid pulses per frame; frame_done 101 cycles after VSYNC entry; next vsync follows immediately.
- Ramp data: pattern 1 -> bytes captured on pix_valid are 10,20,30,40,10,20,30,40 per line; pix_data is stable for all 4 cycles of each slot.
- Frame counter: pattern 2, run 3 frames -> line bytes are 0..7, then 1..8, then 2..9. Separately, force frame_cnt from 255 -> next frame bytes are 0..7 (wrap).
- Enable drop: deassert enable at cycle 40 of a frame -> frame completes with all 24 strobes, frame_done pulses, state returns to IDLE, busy=0, no further vsync.
- Pattern latch: change pattern_sel 0->3 mid-frame -> current frame stays at BASE_VAL=10; next frame line 2 bytes are 2^idx = 2,3,0,1,6,7,4,5.
- Async reset: assert reset mid-ACTIVE between clock edges -> vsync, href, pix_valid, pix_data and frame_done go to 0 immediately; after release with enable=1, a full frame is produced starting with vsync.

Source files
------------

// File: rtl/cam_stream_pkg.sv
// Shared types and helpers for the camera-style stream transmitter.
// Holds the frame-timing state encoding and the test-pattern codes.
package cam_stream_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        HBLANK = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    localparam logic [1:0] PAT_CONST = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_INCR  = 2'd2;
    localparam logic [1:0] PAT_XOR   = 2'd3;

    // Counter width for a range 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_stream_tx_pattern.sv
// Combinational test-pattern source: maps (pattern, byte index, row,
// frame count) to one output byte; all arithmetic wraps modulo 256.
module cam_pattern_gen
    import cam_stream_pkg::*;
#(
    parameter logic [7:0] BASE_VAL = 8'd10
) (
    input  logic [1:0] pattern,
    input  logic [7:0] byte_idx,
    input  logic [7:0] row,
    input  logic [7:0] frame_cnt,
    output logic [7:0] pix_byte
);

    logic [7:0] ramp_step_s;

    // Pattern selection; the ramp repeats 10, 20, 30, 40 on the two low index bits.
    always_comb begin
        ramp_step_s = {6'd0, byte_idx[1:0]} + 8'd1;
        pix_byte    = BASE_VAL;
        case (pattern)
            PAT_CONST: pix_byte = BASE_VAL;
            PAT_RAMP:  pix_byte = ramp_step_s * 8'd10;
            PAT_INCR:  pix_byte = byte_idx + frame_cnt;
            PAT_XOR:   pix_byte = row ^ byte_idx;
            default:   pix_byte = BASE_VAL;
        endcase
    end

endmodule

// File: rtl/cam_stream_tx.sv
// OV-style sensor stand-in: produces vsync/href frame timing and a byte
// stream with a one-cycle strobe per byte slot; all outputs registered.
module cam_stream_tx
    import cam_stream_pkg::*;
#(
    parameter int H_BYTES    = 320,
    parameter int V_LINES    = 150,
    parameter int BYTE_DIV   = 4,
    parameter int STROBE_OFS = 1,
    parameter int VSYNC_LEN  = 1,
    parameter int V_BACK     = 1,
    parameter int H_BLANK    = 1,
    parameter int BASE_VAL   = 10
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       vsync,
    output logic       href,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam int BW = cnt_width(H_BYTES);
    localparam int RW = cnt_width(V_LINES);
    localparam int SW = cnt_width(BYTE_DIV);

    localparam logic [BW-1:0] BYTE_LAST  = BW'(H_BYTES - 1);
    localparam logic [BW-1:0] BYTE_ONE   = BW'(1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(V_LINES - 1);
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(BYTE_DIV - 1);
    localparam logic [SW-1:0] SLOT_ONE   = SW'(1);
    localparam logic [SW-1:0] STROBE_PRE = SW'(STROBE_OFS - 1);
    localparam logic [15:0]   VSYNC_LAST = 16'(VSYNC_LEN - 1);
    localparam logic [15:0]   VBACK_LAST = 16'(V_BACK - 1);
    localparam logic [15:0]   HBLK_LAST  = 16'(H_BLANK - 1);

    state_t        state_r;
    logic [15:0]   phase_cnt_r;
    logic [BW-1:0] byte_idx_r;
    logic [RW-1:0] row_r;
    logic [SW-1:0] slot_cnt_r;
    logic [7:0]    frame_cnt_r;
    logic [1:0]    pattern_r;
    logic [7:0]    gen_idx_s;
    logic [7:0]    gen_byte_s;

    // Index of the byte about to be loaded: 0 when entering a line, else the next slot.
    always_comb begin
        if (state_r == ACTIVE) begin
            gen_idx_s = 8'(byte_idx_r) + 8'd1;
        end else begin
            gen_idx_s = 8'd0;
        end
    end

    cam_pattern_gen #(
        .BASE_VAL (8'(BASE_VAL))
    ) u_pattern (
        .pattern   (pattern_r),
        .byte_idx  (gen_idx_s),
        .row       (8'(row_r)),
        .frame_cnt (frame_cnt_r),
        .pix_byte  (gen_byte_s)
    );

    // Frame timing FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            phase_cnt_r <= 16'd0;
            byte_idx_r  <= '0;
            row_r       <= '0;
            slot_cnt_r  <= '0;
            frame_cnt_r <= 8'd0;
            pattern_r   <= PAT_CONST;
            vsync       <= 1'b0;
            href        <= 1'b0;
            pix_data    <= 8'd0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;
            case (state_r)
                IDLE: begin
                    vsync <= 1'b0;
                    href  <= 1'b0;
                    busy  <= 1'b0;
                    if (enable) begin
                        state_r     <= VSYNC;
                        vsync       <= 1'b1;
                        busy        <= 1'b1;
                        phase_cnt_r <= 16'd0;
                        pattern_r   <= pattern_sel;
                    end
                end
                VSYNC: begin
                    if (phase_cnt_r == VSYNC_LAST) begin
                        state_r     <= VBACK;
                        vsync       <= 1'b0;
                        phase_cnt_r <= 16'd0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                VBACK: begin
                    if (phase_cnt_r == VBACK_LAST) begin
                        state_r     <= HBLANK;
                        row_r       <= '0;
                        phase_cnt_r <= 16'd0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                HBLANK: begin
                    if (phase_cnt_r == HBLK_LAST) begin
                        state_r    <= ACTIVE;
                        href       <= 1'b1;
                        byte_idx_r <= '0;
                        slot_cnt_r <= '0;
                        pix_data   <= gen_byte_s;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                ACTIVE: begin
                    if (slot_cnt_r != SLOT_LAST) begin
                        slot_cnt_r <= slot_cnt_r + SLOT_ONE;
                        pix_valid  <= (slot_cnt_r == STROBE_PRE);
                    end else if (byte_idx_r != BYTE_LAST) begin
                        slot_cnt_r <= '0;
                        byte_idx_r <= byte_idx_r + BYTE_ONE;
                        pix_data   <= gen_byte_s;
                    end else begin
                        // Last slot of the line: href falls on this edge.
                        href        <= 1'b0;
                        slot_cnt_r  <= '0;
                        byte_idx_r  <= '0;
                        phase_cnt_r <= 16'd0;
                        if (row_r == ROW_LAST) begin
                            row_r       <= '0;
                            frame_done  <= 1'b1;
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                            if (enable) begin
                                state_r   <= VSYNC;
                                vsync     <= 1'b1;
                                pattern_r <= pattern_sel;
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            row_r   <= row_r + ROW_ONE;
                            state_r <= HBLANK;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    vsync   <= 1'b0;
                    href    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Self-checking bench for cam_stream_tx with a small frame geometry;
// strobed bytes are checked against a scoreboard filled at each frame start.
`timescale 1ns/1ps
module tb_cam_stream_tx;

    localparam int H_BYTES    = 8;
    localparam int V_LINES    = 3;
    localparam int BYTE_DIV   = 4;
    localparam int STROBE_OFS = 1;
    localparam int VSYNC_LEN  = 1;
    localparam int V_BACK     = 1;
    localparam int H_BLANK    = 1;
    localparam int BASE_VAL   = 10;
    localparam int FRAME_CYC  = VSYNC_LEN + V_BACK + V_LINES * (H_BLANK + H_BYTES * BYTE_DIV);

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       vsync, href, pix_valid, frame_done, busy;
    logic [7:0] pix_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [7:0] m_fc = 8'd0;
    logic       prev_vsync = 1'b0;
    logic       prev_href = 1'b0;
    logic [7:0] prev_data = 8'd0;
    int         href_run = 0;
    int         cyc = 0;
    int         n_href = 0, n_lines = 0, n_strobes = 0, n_vsync = 0;

    cam_stream_tx #(
        .H_BYTES(H_BYTES), .V_LINES(V_LINES), .BYTE_DIV(BYTE_DIV), .STROBE_OFS(STROBE_OFS),
        .VSYNC_LEN(VSYNC_LEN), .V_BACK(V_BACK), .H_BLANK(H_BLANK), .BASE_VAL(BASE_VAL)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .vsync(vsync), .href(href), .pix_data(pix_data), .pix_valid(pix_valid),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] exp_byte(input logic [1:0] pat, input int idx, input int row,
                                            input logic [7:0] fc);
        logic [7:0] i8;
        logic [7:0] r8;
        i8 = idx[7:0];
        r8 = row[7:0];
        case (pat)
            2'd0:    return 8'(BASE_VAL);
            2'd1:    return 8'(((idx % 4) + 1) * 10);
            2'd2:    return i8 + fc;
            default: return r8 ^ i8;
        endcase
    endfunction

    // One clock: sample 1ns after the edge, fill scoreboard at frame start, check strobes/invariants.
    task automatic tick();
        logic [7:0] exp;
        @(posedge pclk);
        #1;
        cyc++;
        if (reset) begin
            sb.delete();
            m_fc     = 8'd0;
            href_run = 0;
        end else begin
            if (vsync && !prev_vsync) begin
                for (int r = 0; r < V_LINES; r++)
                    for (int i = 0; i < H_BYTES; i++)
                        sb.push_back(exp_byte(pattern_sel, i, r, m_fc));
                m_fc = m_fc + 8'd1;
            end
            if (vsync) n_vsync++;
            if (href) begin
                n_href++;
                if (!prev_href) begin
                    n_lines++;
                    href_run = 0;
                end else begin
                    href_run++;
                end
            end
            checks++;
            if (vsync && href) begin
                errors++;
                $display("FAIL sync_overlap: vsync=%b href=%b, required not both high", vsync, href);
            end
            checks++;
            if (pix_valid && !href) begin
                errors++;
                $display("FAIL strobe_outside_href: pix_valid=%b href=%b", pix_valid, href);
            end
            if (href && prev_href && (href_run % BYTE_DIV) != 0) begin
                checks++;
                if (pix_data !== prev_data) begin
                    errors++;
                    $display("FAIL slot_hold: pix_data=%0d, required held %0d", pix_data, prev_data);
                end
            end
            if (pix_valid) begin
                n_strobes++;
                checks++;
                if ((href_run % BYTE_DIV) != STROBE_OFS) begin
                    errors++;
                    $display("FAIL strobe_pos: slot %0d, required %0d", href_run % BYTE_DIV, STROBE_OFS);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_data: got %0d with no byte expected", pix_data);
                end else begin
                    exp = sb.pop_front();
                    if (pix_data !== exp) begin
                        errors++;
                        $display("FAIL strobe_data: got %0d, expected %0d", pix_data, exp);
                    end
                end
            end
        end
        prev_vsync = vsync;
        prev_href  = href;
        prev_data  = pix_data;
    endtask

    task automatic wait_fdone(input int budget, input string name, output int took);
        took = 0;
        do begin
            tick();
            took++;
        end while (!frame_done && took < budget);
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL %s: frame_done=0 after %0d cycles, required pulse", name, budget);
        end
    endtask

    task automatic wait_sig(input int budget, input int which, input string name);
        int   n;
        logic hit;
        n = 0;
        do begin
            tick();
            n++;
            hit = (which == 0) ? vsync : pix_valid;
        end while (!hit && n < budget);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: no event within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
        tick(); tick();
        checks++;
        if ({vsync, href, pix_valid, frame_done, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {vs,hr,pv,fd,busy}=%b, expected 00000",
                     {vsync, href, pix_valid, frame_done, busy});
        end
        checks++;
        if (pix_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d, expected 0", pix_data);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || vsync !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b vsync=%b, expected 0 0", busy, vsync);
        end
    endtask

    task automatic test_frame_timing();
        int t0, vw, took;
        pattern_sel = 2'd1; enable = 1'b1;
        wait_sig(10, 0, "vsync_start");
        t0 = cyc; vw = 1;
        n_href = 0; n_lines = 0; n_strobes = 0;
        while (vsync && vw < 20) begin
            tick();
            if (vsync) vw++;
        end
        checks++;
        if (vw != VSYNC_LEN) begin errors++; $display("FAIL vsync_width: got %0d, expected %0d", vw, VSYNC_LEN); end
        wait_fdone(200, "timing_fdone", took);
        checks++;
        if (cyc - t0 != FRAME_CYC) begin errors++; $display("FAIL frame_period: got %0d, expected %0d", cyc - t0, FRAME_CYC); end
        checks++;
        if (n_href != V_LINES * H_BYTES * BYTE_DIV) begin
            errors++; $display("FAIL href_cycles: got %0d, expected %0d", n_href, V_LINES * H_BYTES * BYTE_DIV);
        end
        checks++;
        if (n_lines != V_LINES) begin errors++; $display("FAIL line_count: got %0d, expected %0d", n_lines, V_LINES); end
        checks++;
        if (n_strobes != V_LINES * H_BYTES) begin
            errors++; $display("FAIL strobe_count: got %0d, expected %0d", n_strobes, V_LINES * H_BYTES);
        end
        checks++;
        if (vsync !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL next_vsync: vsync=%b busy=%b, expected 1 1", vsync, busy);
        end
    endtask

    task automatic test_ramp_hold();
        int took;
        n_strobes = 0;
        wait_fdone(200, "ramp_fdone", took);
        checks++;
        if (n_strobes != V_LINES * H_BYTES) begin
            errors++; $display("FAIL ramp_strobes: got %0d, expected %0d", n_strobes, V_LINES * H_BYTES);
        end
    endtask

    task automatic test_frame_counter();
        int took;
        pattern_sel = 2'd2;
        for (int f = 0; f < 4; f++) wait_fdone(200, "incr_fdone", took);
        for (int f = 0; f < 300 && m_fc != 8'd1; f++) wait_fdone(200, "wrap_fdone", took);
        wait_sig(20, 1, "wrap_strobe");
        checks++;
        if (pix_data !== 8'd0) begin errors++; $display("FAIL frame_cnt_wrap: got %0d, expected 0", pix_data); end
    endtask

    task automatic test_enable_drop();
        int t0, took;
        wait_fdone(200, "drop_sync", took);
        t0 = cyc; n_strobes = 0;
        repeat (39) tick();
        enable = 1'b0;
        wait_fdone(200, "drop_fdone", took);
        checks++;
        if (n_strobes != V_LINES * H_BYTES) begin
            errors++; $display("FAIL drop_strobes: got %0d, expected %0d", n_strobes, V_LINES * H_BYTES);
        end
        checks++;
        if (cyc - t0 != FRAME_CYC) begin errors++; $display("FAIL drop_period: got %0d, expected %0d", cyc - t0, FRAME_CYC); end
        checks++;
        if (busy !== 1'b0 || vsync !== 1'b0) begin
            errors++; $display("FAIL drop_idle: busy=%b vsync=%b, expected 0 0", busy, vsync);
        end
        n_vsync = 0;
        repeat (150) tick();
        checks++;
        if (n_vsync != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_quiet: vsync cycles=%0d busy=%b, expected 0 0", n_vsync, busy);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drop_leftover: %0d bytes missing, expected 0", sb.size()); end
    endtask

    task automatic test_pattern_latch();
        logic [7:0] line2_exp [8];
        int k, took;
        line2_exp = '{8'd2, 8'd3, 8'd0, 8'd1, 8'd6, 8'd7, 8'd4, 8'd5};
        pattern_sel = 2'd0; enable = 1'b1;
        wait_sig(10, 0, "latch_vsync");
        repeat (50) tick();
        pattern_sel = 2'd3;
        wait_fdone(200, "latch_fdone0", took);
        k = 0; n_lines = 0; took = 0;
        do begin
            tick();
            took++;
            if (pix_valid && n_lines == V_LINES && k < H_BYTES) begin
                checks++;
                if (pix_data !== line2_exp[k]) begin
                    errors++; $display("FAIL xor_line2[%0d]: got %0d, expected %0d", k, pix_data, line2_exp[k]);
                end
                k++;
            end
        end while (!frame_done && took < 200);
        checks++;
        if (!frame_done || k != H_BYTES) begin
            errors++; $display("FAIL xor_frame: frame_done=%b bytes=%0d, expected 1 %0d", frame_done, k, H_BYTES);
        end
    endtask

    task automatic test_async_reset();
        int t0, took;
        wait_sig(60, 1, "rst_strobe1");
        wait_sig(10, 1, "rst_strobe2");
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({vsync, href, pix_valid, frame_done} !== 4'b0) begin
            errors++; $display("FAIL async_ctrl: {vs,hr,pv,fd}=%b, expected 0000", {vsync, href, pix_valid, frame_done});
        end
        checks++;
        if (pix_data !== 8'd0) begin errors++; $display("FAIL async_data: got %0d, expected 0", pix_data); end
        tick(); tick();
        #4 reset = 1'b0;
        tick();
        checks++;
        if (vsync !== 1'b1) begin errors++; $display("FAIL restart_vsync: got %b, expected 1", vsync); end
        t0 = cyc; n_strobes = 0; n_lines = 0;
        enable = 1'b0;
        wait_fdone(200, "restart_fdone", took);
        checks++;
        if (cyc - t0 != FRAME_CYC || n_strobes != V_LINES * H_BYTES || n_lines != V_LINES) begin
            errors++;
            $display("FAIL restart_frame: period=%0d strobes=%0d lines=%0d, expected %0d %0d %0d",
                     cyc - t0, n_strobes, n_lines, FRAME_CYC, V_LINES * H_BYTES, V_LINES);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL restart_end: busy=%b left=%0d, expected 0 0", busy, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_ramp_hold();
        test_frame_counter();
        test_enable_drop();
        test_pattern_latch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
